// File: rtl/conv_mac_accumulator_if.sv
// Tap/result bus of the int8 MAC accumulator.
// Carries stall, abort, tap operands and window result.
interface conv_mac_accumulator_if;
    logic        en;
    logic        clear;
    logic        in_valid;
    logic [7:0]  act_in;
    logic [7:0]  wt_in;
    logic [31:0] bias_in;
    logic [31:0] data_out;
    logic        out_valid;

    modport master (
        output en,
        output clear,
        output in_valid,
        output act_in,
        output wt_in,
        output bias_in,
        input  data_out,
        input  out_valid
    );

    modport slave (
        input  en,
        input  clear,
        input  in_valid,
        input  act_in,
        input  wt_in,
        input  bias_in,
        output data_out,
        output out_valid
    );
endinterface

// File: rtl/conv_mac_accumulator.sv
// Int8 x int8 MAC with per-window bias and int32 saturation.
// Two stages: P registers the product, A accumulates K of them.
module conv_mac_accumulator #(
    parameter int K     = 9,
    parameter int CNT_W = 10
) (
    input logic                   clk,
    input logic                   rst_b,
    conv_mac_accumulator_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] acc_cnt;
    logic [15:0]      prod;
    logic             prod_v;
    logic [31:0]      bias_r;
    logic [31:0]      acc;
    logic [31:0]      data_r;
    logic             valid_r;

    logic [15:0]      act_x;
    logic [15:0]      wt_x;
    logic [15:0]      mul;
    logic [31:0]      base;
    logic [32:0]      sum;
    logic [31:0]      sat;

    // Exact 16-bit product and the clamped 33-bit running sum.
    always_comb begin
        act_x = {{8{bus.act_in[7]}}, bus.act_in};
        wt_x  = {{8{bus.wt_in[7]}}, bus.wt_in};
        mul   = act_x * wt_x;
        base  = (acc_cnt == '0) ? bias_r : acc;
        sum   = {base[31], base} + {{17{prod[15]}}, prod};
        sat   = sum[31:0];
        if (sum[32] != sum[31]) begin
            sat = sum[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
    end

    // Stage P: register product, capture bias on tap 0, count taps.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            in_cnt <= '0;
            prod   <= '0;
            prod_v <= 1'b0;
            bias_r <= '0;
        end else if (bus.en) begin
            if (bus.clear) begin
                in_cnt <= '0;
                prod_v <= 1'b0;
            end else if (bus.in_valid) begin
                prod   <= mul;
                prod_v <= 1'b1;
                if (in_cnt == '0) begin
                    bias_r <= bus.bias_in;
                end
                if (in_cnt == LAST) begin
                    in_cnt <= '0;
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end else begin
                prod_v <= 1'b0;
            end
        end
    end

    // Stage A: accumulate products, emit window sum as a pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_cnt <= '0;
            acc     <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (bus.en) begin
            valid_r <= 1'b0;
            if (bus.clear) begin
                acc_cnt <= '0;
                acc     <= '0;
            end else if (prod_v) begin
                if (acc_cnt == LAST) begin
                    data_r  <= sat;
                    valid_r <= 1'b1;
                    acc_cnt <= '0;
                end else begin
                    acc     <= sat;
                    acc_cnt <= acc_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.data_out  = data_r;
    assign bus.out_valid = valid_r;
endmodule
